rgb_to_colour: RTL and testbench



---
 rtl/rgb_to_colour_pkg.sv | 28 ++
 rtl/rgb_to_colour_distance.sv | 20 ++
 rtl/rgb_to_colour.sv | 152 +++++++++++++++
 tb/tb_rgb_to_colour.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_colour_pkg.sv
// Shared definitions for the RGB-to-palette-index reverse lookup.
// Holds default widths, the scan FSM state type, channel slice positions and a channel helper.
package rgb_to_colour_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 24;
   localparam int CH_W       = 8;
   // Worst case is 3 * 255 = 765, which fits in 10 bits without overflow.
   localparam int DIST_W     = 10;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      FINISH = 2'd2
   } state_e;

   function automatic logic [CH_W-1:0] absDiff(input logic [CH_W-1:0] a, input logic [CH_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/rgb_to_colour_distance.sv
// Combinational Manhattan distance |dR|+|dG|+|dB| between two packed RGB words.
module rgb_distance
   import rgb_to_colour_pkg::*;
(
   input  logic [DATA_W_DEF-1:0] a_i,
   input  logic [DATA_W_DEF-1:0] b_i,
   output logic [DIST_W-1:0]     dist_o
);

   logic [CH_W-1:0] dRed;
   logic [CH_W-1:0] dGreen;
   logic [CH_W-1:0] dBlue;

   assign dRed   = absDiff(a_i[R_HI:R_LO], b_i[R_HI:R_LO]);
   assign dGreen = absDiff(a_i[G_HI:G_LO], b_i[G_HI:G_LO]);
   assign dBlue  = absDiff(a_i[B_HI:B_LO], b_i[B_HI:B_LO]);

   assign dist_o = DIST_W'(dRed) + DIST_W'(dGreen) + DIST_W'(dBlue);

endmodule

// File: rtl/rgb_to_colour.sv
// Reverse palette lookup: scans the external palette BRAM for the index holding a given RGB value.
// Optional feature macro NEAREST_MATCH_EN: full scan reporting the nearest entry by |dR|+|dG|+|dB|.
module rgb_to_colour
   import rgb_to_colour_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] rgb_in,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] colour,
   output logic              found
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   state_e            stateQ;
   logic [DATA_W-1:0] rgbQ;
   logic [ADDR_W-1:0] memAddrQ;
   logic [ADDR_W-1:0] cmpIdxQ;
   logic [ADDR_W-1:0] colourQ;
   logic              cmpValidQ;
   logic              memEnQ;
   logic              busyQ;
   logic              doneQ;
   logic              foundQ;
   logic              isLast;

   assign isLast = (cmpIdxQ == LAST_IDX);

`ifdef NEAREST_MATCH_EN
   logic [DIST_W-1:0] dist;
   logic [DIST_W-1:0] bestDistQ;
   logic [DIST_W-1:0] candDist;
   logic [ADDR_W-1:0] bestIdxQ;
   logic [ADDR_W-1:0] candIdx;

   rgb_distance uDistance (
      .a_i    (mem_dout),
      .b_i    (rgbQ),
      .dist_o (dist)
   );

   // Index 0 seeds the running minimum; strict less-than keeps the lowest index on ties.
   always_comb begin
      candDist = bestDistQ;
      candIdx  = bestIdxQ;
      if ((cmpIdxQ == '0) || (dist < bestDistQ)) begin
         candDist = dist;
         candIdx  = cmpIdxQ;
      end
   end
`else
   logic isMatch;
   assign isMatch = (mem_dout == rgbQ);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ    <= IDLE;
         rgbQ      <= '0;
         memAddrQ  <= '0;
         cmpIdxQ   <= '0;
         colourQ   <= '0;
         cmpValidQ <= 1'b0;
         memEnQ    <= 1'b0;
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
         foundQ    <= 1'b0;
`ifdef NEAREST_MATCH_EN
         bestDistQ <= '0;
         bestIdxQ  <= '0;
`endif
      end else begin
         doneQ <= 1'b0;
         case (stateQ)
            // FINISH also accepts start so searches can run back to back.
            IDLE, FINISH: begin
               stateQ <= IDLE;
               memEnQ <= 1'b0;
               busyQ  <= 1'b0;
               if (start) begin
                  rgbQ      <= rgb_in;
                  colourQ   <= '0;
                  foundQ    <= 1'b0;
                  memAddrQ  <= '0;
                  memEnQ    <= 1'b1;
                  busyQ     <= 1'b1;
                  cmpValidQ <= 1'b0;
                  stateQ    <= SCAN;
               end
            end

            SCAN: begin
               if (memAddrQ != LAST_IDX) begin
                  memAddrQ <= memAddrQ + 1'b1;
               end
               // mem_dout lags the issued address by one cycle, so the compare index trails it.
               cmpIdxQ   <= memAddrQ;
               cmpValidQ <= 1'b1;
               if (cmpValidQ) begin
`ifdef NEAREST_MATCH_EN
                  bestDistQ <= candDist;
                  bestIdxQ  <= candIdx;
                  if (isLast) begin
                     colourQ  <= candIdx;
                     foundQ   <= (candDist == '0);
                     stateQ   <= FINISH;
                     busyQ    <= 1'b0;
                     memEnQ   <= 1'b0;
                     memAddrQ <= '0;
                     doneQ    <= 1'b1;
                  end
`else
                  if (isMatch || isLast) begin
                     colourQ  <= isMatch ? cmpIdxQ : '0;
                     foundQ   <= isMatch;
                     stateQ   <= FINISH;
                     busyQ    <= 1'b0;
                     memEnQ   <= 1'b0;
                     memAddrQ <= '0;
                     doneQ    <= 1'b1;
                  end
`endif
               end
            end

            default: begin
               stateQ <= IDLE;
               busyQ  <= 1'b0;
               memEnQ <= 1'b0;
            end
         endcase
      end
   end

   assign mem_en   = memEnQ;
   assign mem_addr = memAddrQ;
   assign busy     = busyQ;
   assign done     = doneQ;
   assign colour   = colourQ;
   assign found    = foundQ;

endmodule

// File: tb/tb_rgb_to_colour.sv
// Directed self-checking bench for rgb_to_colour with a behavioural 8-entry palette BRAM.
module tb_rgb_to_colour;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [23:0] rgb_in = '0;
   logic        mem_en;
   logic [2:0]  mem_addr;
   logic [23:0] memDout = '0;
   logic        busy;
   logic        done;
   logic [2:0]  colour;
   logic        found;

   int checkCount = 0;
   int errCount   = 0;

   rgb_to_colour dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .rgb_in   (rgb_in),
      .mem_en   (mem_en),
      .mem_addr (mem_addr),
      .mem_dout (memDout),
      .busy     (busy),
      .done     (done),
      .colour   (colour),
      .found    (found)
   );

   always #5 clk = ~clk;

   // Palette: index bit 2/1/0 turns the R/G/B channel fully on.
   function automatic logic [23:0] paletteEntry(input logic [2:0] i);
      return {{8{i[2]}}, {8{i[1]}}, {8{i[0]}}};
   endfunction

   always @(posedge clk) begin
      if (mem_en) memDout <= paletteEntry(mem_addr);
   end

   function automatic int latFor(input int k, input bit hit);
`ifdef NEAREST_MATCH_EN
      return 9;
`else
      return hit ? (k + 2) : 9;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Waits for done after an accepted start (E0 already passed), returning edges counted since E0.
   task automatic waitDone(input bit pokeBusy, output int edges, output bit seen);
      edges = 0;
      seen  = 1'b0;
      while (!seen && edges < 20) begin
         if (pokeBusy && edges == 2) begin
            start  = 1'b1;
            rgb_in = 24'h000000;
         end else if (pokeBusy) begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         edges++;
         if (done) seen = 1'b1;
      end
      if (pokeBusy) start = 1'b0;
   endtask

   task automatic applyStimulus(input string tag, input logic [23:0] rgb, input logic [2:0] expColour,
                                input logic expFound, input int expLat, input bit pokeBusy);
      int edges;
      bit seen;
      @(negedge clk);
      start  = 1'b1;
      rgb_in = rgb;
      @(posedge clk); #1;
      start  = 1'b0;
      rgb_in = 24'hA5A5A5;
      checkOutput({tag, ".busyAfterE0"}, 32'(busy), 32'd1);
      checkOutput({tag, ".memEnAfterE0"}, 32'(mem_en), 32'd1);
      checkOutput({tag, ".foundCleared"}, 32'(found), 32'd0);
      waitDone(pokeBusy, edges, seen);
      checkOutput({tag, ".doneSeen"}, 32'(seen), 32'd1);
      checkOutput({tag, ".latency"}, 32'(edges), 32'(expLat));
      checkOutput({tag, ".colour"}, 32'(colour), 32'(expColour));
      checkOutput({tag, ".found"}, 32'(found), 32'(expFound));
      checkOutput({tag, ".busyAtDone"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      checkOutput({tag, ".donePulse"}, 32'(done), 32'd0);
      checkOutput({tag, ".colourHeld"}, 32'(colour), 32'(expColour));
   endtask

   initial begin
      int edges;
      bit seen;
      bit doneDuringReset;

      $display("[TB] rgb_to_colour directed test");
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.done", 32'(done), 32'd0);
      checkOutput("reset.colour", 32'(colour), 32'd0);
      checkOutput("reset.found", 32'(found), 32'd0);
      checkOutput("reset.memEn", 32'(mem_en), 32'd0);
      checkOutput("reset.memAddr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset two cycles into a scan aborts it without a done pulse.
      @(negedge clk);
      start  = 1'b1;
      rgb_in = 24'hFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midReset.busy", 32'(busy), 32'd0);
      checkOutput("midReset.memEn", 32'(mem_en), 32'd0);
      checkOutput("midReset.memAddr", 32'(mem_addr), 32'd0);
      checkOutput("midReset.colour", 32'(colour), 32'd0);
      checkOutput("midReset.found", 32'(found), 32'd0);
      doneDuringReset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (done) doneDuringReset = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (done) doneDuringReset = 1'b1;
      end
      checkOutput("midReset.noDone", 32'(doneDuringReset), 32'd0);
      checkOutput("midReset.idleBusy", 32'(busy), 32'd0);

      applyStimulus("black", 24'h000000, 3'd0, 1'b1, latFor(0, 1'b1), 1'b0);
      applyStimulus("magenta", 24'hFF00FF, 3'd5, 1'b1, latFor(5, 1'b1), 1'b1);
      applyStimulus("yellow", 24'hFFFF00, 3'd6, 1'b1, latFor(6, 1'b1), 1'b0);
      applyStimulus("noMatch", 24'h123456, 3'd0, 1'b0, latFor(0, 1'b0), 1'b0);

      // Back-to-back: start stays high through the first done cycle.
      @(negedge clk);
      start  = 1'b1;
      rgb_in = 24'hFFFFFF;
      @(posedge clk); #1;
      rgb_in = 24'h00FF00;
      waitDone(1'b0, edges, seen);
      checkOutput("b2b1.doneSeen", 32'(seen), 32'd1);
      checkOutput("b2b1.latency", 32'(edges), 32'(latFor(7, 1'b1)));
      checkOutput("b2b1.colour", 32'(colour), 32'd7);
      checkOutput("b2b1.found", 32'(found), 32'd1);
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("b2b2.busyAgain", 32'(busy), 32'd1);
      checkOutput("b2b2.doneLow", 32'(done), 32'd0);
      checkOutput("b2b2.colourCleared", 32'(colour), 32'd0);
      waitDone(1'b0, edges, seen);
      checkOutput("b2b2.doneSeen", 32'(seen), 32'd1);
      checkOutput("b2b2.latency", 32'(edges), 32'(latFor(2, 1'b1)));
      checkOutput("b2b2.colour", 32'(colour), 32'd2);
      checkOutput("b2b2.found", 32'(found), 32'd1);
      @(posedge clk); #1;

`ifdef NEAREST_MATCH_EN
      applyStimulus("nearRed", 24'hF01010, 3'd4, 1'b0, 9, 1'b0);
      applyStimulus("nearGreen", 24'h00FF00, 3'd2, 1'b1, 9, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
